// File: rtl/eai_pkg.sv
// Shared definitions for the EAI instruction dispatcher: default widths,
// funct7 opcodes and FSM state encoding.
package eai_pkg;

    localparam int unsigned EAI_DW       = 32;
    localparam int unsigned EAI_MAX_OUTS = 4;

    localparam logic [6:0] F7_CFG   = 7'h00;
    localparam logic [6:0] F7_LOAD  = 7'h01;
    localparam logic [6:0] F7_STORE = 7'h02;
    localparam logic [6:0] F7_CALC  = 7'h03;
    localparam logic [6:0] F7_FENCE = 7'h04;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEC   = 2'd1,
        S_ISSUE = 2'd2,
        S_FENCE = 2'd3
    } state_e;

endpackage

// File: rtl/eai_outs_counter.sv
// Outstanding-operation counter for one op class; saturates at MAX_OUTS
// and holds at zero, flagging a done pulse that arrives with nothing in flight.
module eai_outs_counter #(
    parameter  int unsigned MAX_OUTS = 4,
    localparam int unsigned OW       = $clog2(MAX_OUTS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] cnt,
    output logic          full,
    output logic          zero,
    output logic          underflow
);

    // Simultaneous issue and completion cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + OW'(1);
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - OW'(1);
        end
    end

    assign full      = (cnt == OW'(MAX_OUTS));
    assign zero      = (cnt == '0);
    assign underflow = dec && zero;

endmodule

// File: rtl/eai_inst_dispatcher.sv
// Decodes custom-instruction entries from the ping-pong buffer and issues them
// in order to the DMA or CALC unit, enforcing load/store/calc hazards.
module eai_inst_dispatcher
    import eai_pkg::*;
#(
    parameter int unsigned DW       = EAI_DW,
    parameter int unsigned MAX_OUTS = EAI_MAX_OUTS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_inst,
    input  logic [DW-1:0] in_rs1,
    input  logic [DW-1:0] in_rs2,
    output logic          dma_valid,
    input  logic          dma_ready,
    output logic          dma_is_store,
    output logic [DW-1:0] dma_addr,
    output logic [DW-1:0] dma_cfg,
    input  logic          dma_done,
    input  logic          dma_done_st,
    output logic          calc_valid,
    input  logic          calc_ready,
    output logic [DW-1:0] calc_cfg,
    input  logic          calc_done,
    output logic [DW-1:0] cfg_word,
    output logic          busy,
    output logic          err_illegal,
    output logic          err_underflow
);

    localparam int unsigned OW = $clog2(MAX_OUTS + 1);

    state_e        state_q, state_d;
    logic [6:0]    f7_q;
    logic [DW-1:0] rs1_q, rs2_q, cfg_q, cfg_d;
    logic          cap_en, err_illegal_d;
    logic          ld_inc, st_inc, calc_inc;
    logic          ld_dec, st_dec, calc_dec;
    logic          ld_full, st_full, calc_full;
    logic          ld_zero, st_zero, calc_zero;
    logic          ld_uf, st_uf, calc_uf;
    logic [OW-1:0] ld_cnt, st_cnt, calc_cnt;

    // Only funct7 selects behaviour; the remaining instruction bits are ignored.
    logic unused_inst_bits;
    assign unused_inst_bits = ^in_inst[24:0];

    assign ld_dec   = dma_done && !dma_done_st;
    assign st_dec   = dma_done && dma_done_st;
    assign calc_dec = calc_done;

    eai_outs_counter #(.MAX_OUTS(MAX_OUTS)) u_ld_cnt (
        .clk(clk), .rst_n(rst_n), .inc(ld_inc), .dec(ld_dec),
        .cnt(ld_cnt), .full(ld_full), .zero(ld_zero), .underflow(ld_uf)
    );

    eai_outs_counter #(.MAX_OUTS(MAX_OUTS)) u_st_cnt (
        .clk(clk), .rst_n(rst_n), .inc(st_inc), .dec(st_dec),
        .cnt(st_cnt), .full(st_full), .zero(st_zero), .underflow(st_uf)
    );

    eai_outs_counter #(.MAX_OUTS(MAX_OUTS)) u_calc_cnt (
        .clk(clk), .rst_n(rst_n), .inc(calc_inc), .dec(calc_dec),
        .cnt(calc_cnt), .full(calc_full), .zero(calc_zero), .underflow(calc_uf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            f7_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            cfg_q         <= '0;
            err_illegal   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                f7_q  <= in_inst[31:25];
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end
            cfg_q         <= cfg_d;
            err_illegal   <= err_illegal_d;
            err_underflow <= ld_uf || st_uf || calc_uf;
        end
    end

    // Request valids only depend on counters that can fall while waiting, so
    // once raised they stay high until the handshake.
    always_comb begin
        state_d       = state_q;
        cap_en        = 1'b0;
        cfg_d         = cfg_q;
        err_illegal_d = 1'b0;
        in_ready      = 1'b0;
        dma_valid     = 1'b0;
        calc_valid    = 1'b0;
        ld_inc        = 1'b0;
        st_inc        = 1'b0;
        calc_inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = in_valid;
                if (in_valid) begin
                    cap_en  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                case (f7_q)
                    F7_CFG: begin
                        cfg_d   = rs2_q;
                        state_d = S_IDLE;
                    end
                    F7_LOAD, F7_STORE, F7_CALC: state_d = S_ISSUE;
                    F7_FENCE:                   state_d = S_FENCE;
                    default: begin
                        err_illegal_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                endcase
            end
            S_ISSUE: begin
                case (f7_q)
                    F7_LOAD: begin
                        dma_valid = !ld_full;
                        if (dma_valid && dma_ready) begin
                            ld_inc  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    F7_STORE: begin
                        dma_valid = !st_full && calc_zero;
                        if (dma_valid && dma_ready) begin
                            st_inc  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    F7_CALC: begin
                        calc_valid = !calc_full && ld_zero;
                        if (calc_valid && calc_ready) begin
                            calc_inc = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_FENCE: begin
                if (ld_zero && st_zero && calc_zero) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dma_is_store = (f7_q == F7_STORE);
    assign dma_addr     = rs1_q;
    assign dma_cfg      = rs2_q;
    assign calc_cfg     = rs2_q;
    assign cfg_word     = cfg_q;
    assign busy         = (state_q != S_IDLE) || (ld_cnt != '0) ||
                          (st_cnt != '0) || (calc_cnt != '0);

endmodule

// File: tb/tb_eai_inst_dispatcher.sv
// Directed self-checking bench for eai_inst_dispatcher; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_eai_inst_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_inst, in_rs1, in_rs2;
    logic        dma_valid, dma_ready, dma_is_store;
    logic [31:0] dma_addr, dma_cfg;
    logic        dma_done, dma_done_st;
    logic        calc_valid, calc_ready;
    logic [31:0] calc_cfg;
    logic        calc_done;
    logic [31:0] cfg_word;
    logic        busy, err_illegal, err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eai_inst_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_is_store(dma_is_store),
        .dma_addr(dma_addr), .dma_cfg(dma_cfg),
        .dma_done(dma_done), .dma_done_st(dma_done_st),
        .calc_valid(calc_valid), .calc_ready(calc_ready), .calc_cfg(calc_cfg),
        .calc_done(calc_done),
        .cfg_word(cfg_word), .busy(busy),
        .err_illegal(err_illegal), .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and let combinational outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one entry and hold it until the dispatcher accepts it; returns
    // on the falling edge after the capturing rising edge (state = DEC).
    task automatic push(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] c);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_inst  = {f7, 25'h0};
        in_rs1   = a;
        in_rs2   = c;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1;
            if (in_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic pulse_dma_done(input logic st);
        dma_done    = 1'b1;
        dma_done_st = st;
        step();
        dma_done    = 1'b0;
        dma_done_st = 1'b0;
        #1;
    endtask

    task automatic pulse_calc_done();
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_rs1 = '0; in_rs2 = '0;
        dma_ready = 1'b0; dma_done = 1'b0; dma_done_st = 1'b0;
        calc_ready = 1'b0; calc_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_dma_valid", 32'(dma_valid), 0);
        check("rst_calc_valid", 32'(calc_valid), 0);
        check("rst_cfg_word", cfg_word, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dma_addr", dma_addr, 0);

        // CFG
        push(7'h00, 32'h0, 32'hA5A5_0001);
        check("cfg_busy_dec", 32'(busy), 1);
        step();
        check("cfg_word", cfg_word, 32'hA5A5_0001);
        check("cfg_busy", 32'(busy), 0);
        check("cfg_no_dma", 32'(dma_valid), 0);
        check("cfg_no_calc", 32'(calc_valid), 0);

        // LOAD then CALC gated by the load
        push(7'h01, 32'h1000, 32'h11);
        step();
        check("ld_valid", 32'(dma_valid), 1);
        check("ld_addr", dma_addr, 32'h1000);
        check("ld_is_store", 32'(dma_is_store), 0);
        dma_ready = 1'b1;
        step();
        dma_ready = 1'b0;
        check("ld_cnt1", 32'(dut.ld_cnt), 1);
        push(7'h03, 32'h0, 32'h22);
        calc_ready = 1'b1;
        step();
        check("calc_blocked", 32'(calc_valid), 0);
        step();
        check("calc_blocked2", 32'(calc_valid), 0);
        pulse_dma_done(1'b0);
        check("calc_valid", 32'(calc_valid), 1);
        check("calc_cfg", calc_cfg, 32'h22);
        step();
        calc_ready = 1'b0;
        check("calc_cnt1", 32'(dut.calc_cnt), 1);
        pulse_calc_done();
        check("idle_busy", 32'(busy), 0);

        // Five loads against a limit of four
        dma_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(7'h01, 32'h2000 + 32'(i * 4), 32'h0);
        step();
        check("ld5_cnt", 32'(dut.ld_cnt), 4);
        check("ld5_held", 32'(dma_valid), 0);
        step();
        check("ld5_held2", 32'(dma_valid), 0);
        pulse_dma_done(1'b0);
        check("ld5_valid", 32'(dma_valid), 1);
        check("ld5_addr", dma_addr, 32'h2010);
        step();
        check("ld5_cnt_after", 32'(dut.ld_cnt), 4);
        for (int i = 0; i < 4; i++) pulse_dma_done(1'b0);
        check("ld_drained", 32'(dut.ld_cnt), 0);

        // CALC, STORE, FENCE, CFG ordering
        calc_ready = 1'b1;
        push(7'h03, 32'h0, 32'h33);
        push(7'h02, 32'h3000, 32'h44);
        calc_ready = 1'b0;
        step();
        check("st_blocked", 32'(dma_valid), 0);
        step();
        check("st_blocked2", 32'(dma_valid), 0);
        pulse_calc_done();
        check("st_valid", 32'(dma_valid), 1);
        check("st_is_store", 32'(dma_is_store), 1);
        check("st_addr", dma_addr, 32'h3000);
        step();
        check("st_cnt1", 32'(dut.st_cnt), 1);
        push(7'h04, 32'h0, 32'h0);
        in_valid = 1'b1; in_inst = '0; in_rs2 = 32'h55;
        step();
        check("fence_hold_ready", 32'(in_ready), 0);
        step();
        check("fence_hold_ready2", 32'(in_ready), 0);
        check("fence_cfg_old", cfg_word, 32'hA5A5_0001);
        pulse_dma_done(1'b1);
        push(7'h00, 32'h0, 32'h55);
        step();
        check("fence_cfg_new", cfg_word, 32'h55);
        dma_ready = 1'b0;

        // Illegal opcode and underflow
        push(7'h7F, 32'h0, 32'h0);
        check("ill_pre", 32'(err_illegal), 0);
        step();
        check("ill_pulse", 32'(err_illegal), 1);
        step();
        check("ill_clear", 32'(err_illegal), 0);
        check("ill_busy", 32'(busy), 0);
        pulse_calc_done();
        check("uf_pulse", 32'(err_underflow), 1);
        step();
        check("uf_clear", 32'(err_underflow), 0);
        check("uf_calc_cnt", 32'(dut.calc_cnt), 0);

        // Same-cycle issue and done on loads
        dma_ready = 1'b1;
        push(7'h01, 32'h4000, 32'h0);
        push(7'h01, 32'h4004, 32'h0);
        push(7'h01, 32'h4008, 32'h0);
        step();
        check("same_valid", 32'(dma_valid), 1);
        dma_done = 1'b1; dma_done_st = 1'b0;
        step();
        dma_done = 1'b0;
        #1;
        check("same_cnt", 32'(dut.ld_cnt), 2);

        // Reset while a request is pending
        dma_ready = 1'b0;
        push(7'h01, 32'h5000, 32'h0);
        step();
        check("rst_pre_valid", 32'(dma_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(dma_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_cfg", cfg_word, 0);
        check("rst_mid_addr", dma_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ldcnt", 32'(dut.ld_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
